// File: rtl/fifo_rr_arbiter.sv
// Round-robin drain of NUM_CH input FIFOs into a single egress FIFO.
// A one-entry pending stage covers the input FIFOs' one-cycle read latency.
module fifo_rr_arbiter #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                           clk,
    input  logic                           reset_L,
    input  logic                           enable,
    input  logic [NUM_CH-1:0]              in_empty,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   in_data,
    output logic [NUM_CH-1:0]              in_pop,
    input  logic                           out_almost_full,
    input  logic                           out_full,
    output logic                           out_push,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [$clog2(NUM_CH)-1:0]      grant_id,
    output logic [CNT_WIDTH-1:0]           push_count,
    output logic [1:0]                     state,
    output logic                           err_overflow
);

    localparam int unsigned SelWidth = $clog2(NUM_CH);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StArb  = 2'd1,
        StHold = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [SelWidth-1:0]     last_q;
    logic [SelWidth-1:0]     pend_sel_q;
    logic                    pend_valid_q;
    logic                    out_push_q;
    logic [DATA_WIDTH-1:0]   out_data_q;
    logic [SelWidth-1:0]     grant_id_q;
    logic [CNT_WIDTH-1:0]    push_count_q;
    logic                    err_overflow_q;

    logic                    pop_found;
    logic [SelWidth-1:0]     pop_sel;
    logic [SelWidth-1:0]     cand;
    logic [NUM_CH-1:0]       pop_vec;
    logic [DATA_WIDTH-1:0]   in_words [NUM_CH];

    always_comb begin
        for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            in_words[ch] = in_data[ch*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Search starts one past the last grant; NUM_CH is a power of two so the
    // pointer sum wraps by truncation.
    always_comb begin
        pop_found = 1'b0;
        pop_sel   = last_q;
        cand      = '0;
        pop_vec   = '0;
        if (state_q == StArb && !out_almost_full) begin
            for (int unsigned i = 1; i <= NUM_CH; i++) begin
                cand = last_q + SelWidth'(i);
                if (!pop_found && !in_empty[cand]) begin
                    pop_found = 1'b1;
                    pop_sel   = cand;
                end
            end
        end
        if (pop_found) begin
            pop_vec[pop_sel] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (enable) state_d = StArb;
            end
            StArb: begin
                if (!enable)              state_d = StIdle;
                else if (out_almost_full) state_d = StHold;
            end
            StHold: begin
                if (!enable)               state_d = StIdle;
                else if (!out_almost_full) state_d = StArb;
            end
            default: state_d = StIdle;
        endcase
    end

    // A pending word is pushed regardless of state so no popped word is lost.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q        <= StIdle;
            last_q         <= SelWidth'(NUM_CH - 1);
            pend_sel_q     <= '0;
            pend_valid_q   <= 1'b0;
            out_push_q     <= 1'b0;
            out_data_q     <= '0;
            grant_id_q     <= '0;
            push_count_q   <= '0;
            err_overflow_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_valid_q <= pop_found;
            if (pop_found) begin
                last_q     <= pop_sel;
                pend_sel_q <= pop_sel;
            end
            out_push_q <= pend_valid_q;
            if (pend_valid_q) begin
                out_data_q   <= in_words[pend_sel_q];
                grant_id_q   <= pend_sel_q;
                push_count_q <= push_count_q + 1'b1;
                if (out_full) begin
                    err_overflow_q <= 1'b1;
                end
            end
        end
    end

    assign in_pop       = pop_vec;
    assign out_push     = out_push_q;
    assign out_data     = out_data_q;
    assign grant_id     = grant_id_q;
    assign push_count   = push_count_q;
    assign state        = state_q;
    assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed bench for fifo_rr_arbiter: rotation, sparse channels, back-pressure,
// overflow, asynchronous reset and push counter wrap.
module tb_fifo_rr_arbiter;

    logic        clk;
    logic        reset_L;
    logic        enable;
    logic [3:0]  in_empty;
    logic [15:0] in_data;
    logic [3:0]  in_pop;
    logic        out_almost_full;
    logic        out_full;
    logic        out_push;
    logic [3:0]  out_data;
    logic [1:0]  grant_id;
    logic [7:0]  push_count;
    logic [1:0]  state;
    logic        err_overflow;

    int n_cmp = 0;
    int n_err = 0;

    // Fixed word per channel: ch0=3, ch1=5, ch2=7, ch3=A.
    logic [3:0] ch_word [4];

    fifo_rr_arbiter #(
        .NUM_CH     (4),
        .DATA_WIDTH (4),
        .CNT_WIDTH  (8)
    ) dut (
        .clk             (clk),
        .reset_L         (reset_L),
        .enable          (enable),
        .in_empty        (in_empty),
        .in_data         (in_data),
        .in_pop          (in_pop),
        .out_almost_full (out_almost_full),
        .out_full        (out_full),
        .out_push        (out_push),
        .out_data        (out_data),
        .grant_id        (grant_id),
        .push_count      (push_count),
        .state           (state),
        .err_overflow    (err_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, ".in_pop"}, 32'(in_pop), 32'h0);
        check_eq({tag, ".out_push"}, 32'(out_push), 32'h0);
        check_eq({tag, ".out_data"}, 32'(out_data), 32'h0);
        check_eq({tag, ".grant_id"}, 32'(grant_id), 32'h0);
        check_eq({tag, ".push_count"}, 32'(push_count), 32'h0);
        check_eq({tag, ".state"}, 32'(state), 32'h0);
        check_eq({tag, ".err"}, 32'(err_overflow), 32'h0);
    endtask

    initial begin
        ch_word[0] = 4'h3;
        ch_word[1] = 4'h5;
        ch_word[2] = 4'h7;
        ch_word[3] = 4'hA;
        in_data         = {4'hA, 4'h7, 4'h5, 4'h3};
        reset_L         = 1'b1;
        enable          = 1'b0;
        in_empty        = 4'hF;
        out_almost_full = 1'b0;
        out_full        = 1'b0;
        #3 reset_L = 1'b0;
        #1;
        check_all_zero("reset");

        // Full rotation with every channel non-empty.
        tick();
        reset_L  = 1'b1;
        enable   = 1'b1;
        in_empty = 4'h0;
        #1;
        check_eq("idle_no_pop", 32'(in_pop), 32'h0);
        for (int k = 0; k < 8; k++) begin
            tick();
            #1;
            check_eq("rot.in_pop", 32'(in_pop), 32'(4'b0001 << (k % 4)));
            check_eq("rot.state", 32'(state), 32'd1);
            if (k >= 2) begin
                check_eq("rot.out_push", 32'(out_push), 32'h1);
                check_eq("rot.grant", 32'(grant_id), 32'((k - 2) % 4));
                check_eq("rot.data", 32'(out_data), 32'(ch_word[(k - 2) % 4]));
                check_eq("rot.count", 32'(push_count), 32'(k - 1));
            end else begin
                check_eq("rot.no_push", 32'(out_push), 32'h0);
            end
        end

        // Only channels 0 and 2 non-empty: strict alternation.
        for (int j = 0; j < 6; j++) begin
            tick();
            in_empty = 4'b1010;
            #1;
            check_eq("alt.in_pop", 32'(in_pop), (j % 2 == 0) ? 32'h1 : 32'h4);
            check_eq("alt.count", 32'(push_count), 32'(7 + j));
            check_eq("alt.out_push", 32'(out_push), 32'h1);
            if (j == 0) begin
                check_eq("alt.grant_tail", 32'(grant_id), 32'd2);
            end else if (j == 1) begin
                check_eq("ch3.grant", 32'(grant_id), 32'd3);
                check_eq("ch3.data", 32'(out_data), 32'hA);
            end else begin
                check_eq("alt.grant", 32'(grant_id), (j % 2 == 0) ? 32'd0 : 32'd2);
                check_eq("alt.data", 32'(out_data), (j % 2 == 0) ? 32'h3 : 32'h7);
            end
        end

        // Almost-full back-pressure: pops stop at once, in-flight word drains.
        tick();
        out_almost_full = 1'b1;
        #1;
        check_eq("af.in_pop_now", 32'(in_pop), 32'h0);
        check_eq("af.state_arb", 32'(state), 32'd1);
        check_eq("af.push0", 32'(out_push), 32'h1);
        check_eq("af.grant0", 32'(grant_id), 32'd0);
        check_eq("af.count0", 32'(push_count), 32'd13);
        tick();
        #1;
        check_eq("af.state_hold", 32'(state), 32'd2);
        check_eq("af.in_pop_hold", 32'(in_pop), 32'h0);
        check_eq("af.inflight_push", 32'(out_push), 32'h1);
        check_eq("af.inflight_grant", 32'(grant_id), 32'd2);
        check_eq("af.inflight_data", 32'(out_data), 32'h7);
        check_eq("af.count1", 32'(push_count), 32'd14);
        tick();
        out_almost_full = 1'b0;
        in_empty        = 4'h0;
        #1;
        check_eq("af.drained", 32'(out_push), 32'h0);
        check_eq("af.state_hold2", 32'(state), 32'd2);
        check_eq("af.count2", 32'(push_count), 32'd14);
        tick();
        #1;
        check_eq("resume.state", 32'(state), 32'd1);
        check_eq("resume.in_pop", 32'(in_pop), 32'h8);
        enable = 1'b0;

        // Overflow: push lands while egress reports full, enable already low.
        tick();
        out_full = 1'b1;
        #1;
        check_eq("ovf.state_idle", 32'(state), 32'd0);
        check_eq("ovf.in_pop", 32'(in_pop), 32'h0);
        check_eq("ovf.err_pre", 32'(err_overflow), 32'h0);
        tick();
        out_full = 1'b0;
        #1;
        check_eq("ovf.push", 32'(out_push), 32'h1);
        check_eq("ovf.grant", 32'(grant_id), 32'd3);
        check_eq("ovf.data", 32'(out_data), 32'hA);
        check_eq("ovf.count", 32'(push_count), 32'd15);
        check_eq("ovf.err", 32'(err_overflow), 32'h1);
        tick();
        enable = 1'b1;
        #1;
        check_eq("ovf.sticky", 32'(err_overflow), 32'h1);
        check_eq("ovf.no_push", 32'(out_push), 32'h0);

        // Asynchronous reset right after a pop, between clock edges.
        tick();
        #1;
        check_eq("rst.pop_before", 32'(in_pop), 32'h1);
        #2 reset_L = 1'b0;
        #1;
        check_all_zero("async_rst");
        tick();
        enable  = 1'b0;
        reset_L = 1'b1;
        for (int r = 0; r < 3; r++) begin
            tick();
            #1;
            check_eq("post_rst.no_push", 32'(out_push), 32'h0);
            check_eq("post_rst.count", 32'(push_count), 32'h0);
        end

        // Push counter wrap after 256 pushes.
        tick();
        enable = 1'b1;
        for (int k = 0; k < 258; k++) begin
            tick();
            #1;
            if (k == 2) check_eq("wrap.count_first", 32'(push_count), 32'd1);
            if (k == 256) check_eq("wrap.count_255", 32'(push_count), 32'd255);
            if (k == 257) check_eq("wrap.count_0", 32'(push_count), 32'd0);
        end
        check_eq("wrap.err_cleared", 32'(err_overflow), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_rr_arbiter.md
Name: fifo_rr_arbiter

Overview:
- Sits directly downstream of a bank of NUM_CH instances of the team FIFO, between those FIFOs and the single egress FIFO.
- Pops words from the non-empty input FIFOs in round-robin order and pushes them into the egress FIFO.
- Honours the egress FIFO's almost-full and full flags for back-pressure.
- Bridges the input FIFOs' one-cycle read latency (pop at N, data registered at N+1) with a one-entry pending stage.

Parameters:
NUM_CH, 4, number of input FIFO channels (power of two, 2..8)
DATA_WIDTH, 4, width of one data word
CNT_WIDTH, 8, width of the push counter

Ports:
clk  input  1  clock, all state updates on posedge
reset_L  input  1  asynchronous, active-low reset
enable  input  1  arbitration enable
in_empty  input  NUM_CH  fifo_empty flag of each input FIFO
in_data  input  NUM_CH*DATA_WIDTH  output words of the input FIFOs; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
in_pop  output  NUM_CH  one-hot read strobe to the input FIFOs
out_almost_full  input  1  almost_full flag of the egress FIFO
out_full  input  1  full flag of the egress FIFO
out_push  output  1  write strobe to the egress FIFO
out_data  output  DATA_WIDTH  word to the egress FIFO
grant_id  output  $clog2(NUM_CH)  channel that is the source of the current out_data
push_count  output  CNT_WIDTH  total words pushed, wraps modulo 2^CNT_WIDTH
state  output  2  FSM state: IDLE=0, ARB=1, HOLD=2
err_overflow  output  1  sticky overflow error

Behaviour:
Reset and all-outputs rules:
- Asynchronous reset_L low immediately forces:
  - in_pop=0, out_push=0, out_data=0, grant_id=0, push_count=0, err_overflow=0, state=IDLE.
  - Internal pending_valid=0; round-robin pointer last=NUM_CH-1, so channel 0 has first priority.
- All outputs are registered except in_pop, which is combinational from state, last, in_empty and out_almost_full.
- Reset mid-operation discards any pending word. No push is issued for a word whose pop already occurred.

FSM:
- IDLE -> ARB when enable=1.
- ARB -> HOLD when out_almost_full=1.
- ARB -> IDLE when enable=0.
- HOLD -> ARB when out_almost_full=0 and enable=1.
- HOLD -> IDLE when enable=0.

Pop (ARB only):
- Candidate set is ~in_empty. If the set is non-empty and out_almost_full=0, select the first candidate searching last+1, last+2, ... modulo NUM_CH.
- Drive in_pop[sel]=1 for exactly that cycle; in_pop is never multi-hot.
- At the posedge: last<=sel, pending_sel<=sel, pending_valid<=1. If no pop occurs, pending_valid<=0.
- In IDLE or HOLD, in_pop=0 and last is unchanged.

Push (one cycle after the pop):
- When pending_valid=1 at a posedge:
  - out_push<=1, out_data<=in_data slice[pending_sel], grant_id<=pending_sel.
  - push_count<=push_count+1, wrapping from 2^CNT_WIDTH-1 to 0.
- Otherwise out_push<=0; out_data and grant_id hold their values.
- Pop-to-push latency: pop in cycle N, out_push high in cycle N+2 (registered).
- Pops may be issued every cycle, giving a sustained throughput of one word per cycle.

In-flight words and back-pressure:
- A pending word is always pushed, even if the FSM has gone to HOLD or IDLE, or enable has dropped.
- The egress almost-full threshold must leave at least 2 words of headroom to absorb in-flight words.

Overflow:
- If out_full=1 in the same cycle a push is registered, err_overflow<=1.
- err_overflow is sticky until reset. The push is still issued.

Fairness:
- With a single non-empty channel, that channel is granted every cycle.
- With k non-empty channels, each is granted once per k pops.

Test Plan:
- Reset with all in_empty=0, then enable=1 -> first in_pop=4'b0001; subsequent pops in order 0010, 0100, 1000, 0001.
- in_empty=4'b1010, enable held -> pops alternate channels 0 and 2 every cycle; grant_id sequence 0,2,0,2 delayed 2 cycles; push_count increments by 1 per cycle.
- Channel 3 data=4'hA popped at cycle N -> out_push=1, out_data=4'hA, grant_id=3 at cycle N+2.
- out_almost_full rises while popping every cycle -> state=HOLD next cycle; in_pop=0 immediately; the last in-flight word is still pushed; on deassert, popping resumes at channel last+1.
- out_full=1 when a pending word is pushed -> err_overflow=1 and stays high after out_full falls; cleared only by reset_L=0.
- Assert reset_L=0 asynchronously right after a pop -> all outputs 0 without a clock edge; no push follows release; push_count wraps 255->0 after 256 pushes.
